sprite_compositor: RTL

//  Pipelined N-channel sprite compositor between VGA timing and DAC: per pixel, tests every

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/sprite_compositor_rom.sv | 35 +++
 rtl/sprite_compositor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor pipeline.
package sprite_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned DELTA_W   = 12;
  localparam int unsigned SPR_DIM   = 16;
  localparam int unsigned TEX_W     = 4;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t BACKGROUND_DEFAULT = 12'h002;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

endpackage

// File: rtl/sprite_compositor_rom.sv
// Per-channel sprite texel store, 1-cycle registered read.
// Texels are generated from the address; column 15 of every sprite is transparent.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int unsigned KIND_BITS  = 2,
  parameter int unsigned FRAME_BITS = 2,
  localparam int unsigned ADDR_W    = KIND_BITS + FRAME_BITS + 2 * TEX_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output rgb444_t           rgb
);

  logic [KIND_BITS-1:0]  kind_c;
  logic [FRAME_BITS-1:0] frame_c;
  logic [TEX_W-1:0]      row_c;
  logic [TEX_W-1:0]      col_c;
  rgb444_t               texel_c;

  always_comb begin
    kind_c  = addr[ADDR_W-1 -: KIND_BITS];
    frame_c = addr[2*TEX_W +: FRAME_BITS];
    row_c   = addr[TEX_W +: TEX_W];
    col_c   = addr[0 +: TEX_W];
    texel_c = '0;
    if (col_c != TEX_W'(SPR_DIM - 1))
      texel_c = {1'b1, 3'(frame_c) ^ 3'(kind_c), row_c, col_c};
  end

  always_ff @(posedge clk) begin
    rgb <= texel_c;
  end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: bounds/rotate, ROM read, priority select.
// Sprite attributes are shadowed on frame_tick so a frame never tears.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPR    = 4,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned KIND_BITS  = 2,
  parameter int unsigned NUM_FRAMES = 3,
  parameter int unsigned ANIM_DIV   = 4,
  parameter rgb444_t     BACKGROUND = BACKGROUND_DEFAULT,
  localparam int unsigned SPR_IDX_W = $clog2(NUM_SPR) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic signed [COORD_W-1:0]      x_vga,
  input  logic signed [COORD_W-1:0]      y_vga,
  input  logic                           pix_in_valid,
  input  logic [NUM_SPR-1:0]             spr_en,
  input  logic [COORD_W*NUM_SPR-1:0]     spr_x,
  input  logic [COORD_W*NUM_SPR-1:0]     spr_y,
  input  logic [2*NUM_SPR-1:0]           spr_dir,
  input  logic [KIND_BITS*NUM_SPR-1:0]   spr_kind,
  output rgb444_t                        pix_color,
  output logic                           pix_valid,
  output logic [SPR_IDX_W-1:0]           pix_sprite,
  output logic                           collision
);

  localparam int unsigned FRAME_BITS = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned DIV_BITS   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned ADDR_W     = KIND_BITS + FRAME_BITS + 2 * TEX_W;
  localparam int unsigned OFFSET     = (SPR_DIM / 2) << SCALE_LOG2;
  localparam int unsigned SPAN       = SPR_DIM << SCALE_LOG2;

  logic [NUM_SPR-1:0]    sh_en;
  logic [COORD_W-1:0]    sh_x    [NUM_SPR];
  logic [COORD_W-1:0]    sh_y    [NUM_SPR];
  logic [1:0]            sh_dir  [NUM_SPR];
  logic [KIND_BITS-1:0]  sh_kind [NUM_SPR];
  logic [DIV_BITS-1:0]   anim_div;
  logic [FRAME_BITS-1:0] anim_frame;

  // Attribute shadow: only frame_tick updates what the pipeline sees.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_en <= '0;
      for (int i = 0; i < int'(NUM_SPR); i++) begin
        sh_x[i]    <= '0;
        sh_y[i]    <= '0;
        sh_dir[i]  <= '0;
        sh_kind[i] <= '0;
      end
    end else if (frame_tick) begin
      sh_en <= spr_en;
      for (int i = 0; i < int'(NUM_SPR); i++) begin
        sh_x[i]    <= spr_x[COORD_W*i +: COORD_W];
        sh_y[i]    <= spr_y[COORD_W*i +: COORD_W];
        sh_dir[i]  <= spr_dir[2*i +: 2];
        sh_kind[i] <= spr_kind[KIND_BITS*i +: KIND_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anim_div   <= '0;
      anim_frame <= '0;
    end else if (frame_tick) begin
      if (anim_div == DIV_BITS'(ANIM_DIV - 1)) begin
        anim_div   <= '0;
        anim_frame <= (anim_frame == FRAME_BITS'(NUM_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
      end else begin
        anim_div <= anim_div + 1'b1;
      end
    end
  end

  // Stage 1: per-channel bounds test and direction-dependent texel addressing.
  logic [DELTA_W-1:0] dx_c   [NUM_SPR];
  logic [DELTA_W-1:0] dy_c   [NUM_SPR];
  logic [TEX_W-1:0]   u_c    [NUM_SPR];
  logic [TEX_W-1:0]   v_c    [NUM_SPR];
  logic [TEX_W-1:0]   row_c  [NUM_SPR];
  logic [TEX_W-1:0]   col_c  [NUM_SPR];
  logic [ADDR_W-1:0]  addr_c [NUM_SPR];
  logic [NUM_SPR-1:0] hit_c;
  logic               visible_c;

  always_comb begin
    hit_c     = '0;
    visible_c = (x_vga <= $signed(COORD_W'(H_VISIBLE - 1))) &&
                (y_vga <= $signed(COORD_W'(V_VISIBLE - 1)));
    for (int i = 0; i < int'(NUM_SPR); i++) begin
      dx_c[i] = {x_vga[COORD_W-1], x_vga} - {sh_x[i][COORD_W-1], sh_x[i]} + DELTA_W'(OFFSET);
      dy_c[i] = {y_vga[COORD_W-1], y_vga} - {sh_y[i][COORD_W-1], sh_y[i]} + DELTA_W'(OFFSET);
      u_c[i]  = TEX_W'(dx_c[i] >> SCALE_LOG2);
      v_c[i]  = TEX_W'(dy_c[i] >> SCALE_LOG2);
      hit_c[i] = sh_en[i] && !dx_c[i][DELTA_W-1] && !dy_c[i][DELTA_W-1] &&
                 (dx_c[i] < DELTA_W'(SPAN)) && (dy_c[i] < DELTA_W'(SPAN));
      row_c[i] = u_c[i];
      col_c[i] = v_c[i];
      case (dir_e'(sh_dir[i]))
        DIR_LEFT: row_c[i] = TEX_W'(SPR_DIM - 1) - u_c[i];
        DIR_DOWN: begin
          col_c[i] = u_c[i];
          row_c[i] = v_c[i];
        end
        DIR_UP: begin
          col_c[i] = u_c[i];
          row_c[i] = TEX_W'(SPR_DIM - 1) - v_c[i];
        end
        default: ;
      endcase
      addr_c[i] = {sh_kind[i], anim_frame, row_c[i], col_c[i]};
    end
  end

  logic               s1_valid, s1_visible, s2_valid, s2_visible;
  logic [NUM_SPR-1:0] s1_hit, s2_hit;
  logic [ADDR_W-1:0]  s1_addr [NUM_SPR];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_visible <= 1'b0;
      s1_hit     <= '0;
      s2_valid   <= 1'b0;
      s2_visible <= 1'b0;
      s2_hit     <= '0;
    end else begin
      s1_valid   <= pix_in_valid;
      s1_visible <= visible_c;
      s1_hit     <= hit_c;
      s2_valid   <= s1_valid;
      s2_visible <= s1_visible;
      s2_hit     <= s1_hit;
    end
    s1_addr <= addr_c;
  end

  // Stage 2: one texel ROM per channel.
  rgb444_t rom_rgb [NUM_SPR];

  for (genvar g = 0; g < int'(NUM_SPR); g++) begin : g_rom
    sprite_rom #(
      .KIND_BITS  (KIND_BITS),
      .FRAME_BITS (FRAME_BITS)
    ) u_rom (
      .clk  (clk),
      .addr (s1_addr[g]),
      .rgb  (rom_rgb[g])
    );
  end

  // Stage 3: lowest-index opaque channel wins.
  logic [NUM_SPR-1:0]   opaque_c;
  logic [SPR_IDX_W-1:0] win_c;
  rgb444_t              win_rgb_c;
  logic                 overlap_c;

  always_comb begin
    win_c     = '1;
    win_rgb_c = BACKGROUND;
    for (int i = 0; i < int'(NUM_SPR); i++)
      opaque_c[i] = s2_hit[i] && (rom_rgb[i] != '0);
    for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
      if (opaque_c[i]) begin
        win_c     = SPR_IDX_W'(i);
        win_rgb_c = rom_rgb[i];
      end
    end
    overlap_c = s2_valid && s2_visible && opaque_c[0] && (|opaque_c[NUM_SPR-1:1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_color  <= '0;
      pix_valid  <= 1'b0;
      pix_sprite <= '1;
    end else begin
      pix_valid  <= s2_valid;
      pix_sprite <= win_c;
      pix_color  <= (s2_valid && s2_visible) ? win_rgb_c : '0;
    end
  end

  // Player collision: a hit on the tick cycle still belongs to the closing frame.
  logic coll_accum;

  always_ff @(posedge clk) begin
    if (reset) begin
      coll_accum <= 1'b0;
      collision  <= 1'b0;
    end else if (frame_tick) begin
      collision  <= coll_accum | overlap_c;
      coll_accum <= 1'b0;
    end else if (overlap_c) begin
      coll_accum <= 1'b1;
    end
  end

endmodule
